// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg -- definitions shared by the serial memory loader.
//   state_e       : loader FSM states (CHECK exists only with LOADER_CHECKSUM_EN)
//   UNIT_WORD     : word-unit encoding driven on the mmu unit ports
//   clks_per_bit  : integer-truncated clock cycles per serial bit
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [1:0] UNIT_WORD = 2'd2;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mem_loader_rx.sv
// uart_rx_core -- 8N1 serial receiver.
//   clk_i, rst_ni  : clock, async active-low reset
//   rx_i           : asynchronous serial line, idle high
//   byte_o         : last received byte
//   byte_valid_o   : one-cycle pulse, byte_o holds a good frame
//   frame_err_o    : one-cycle pulse, stop bit sampled low
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int          CW   = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

  // [1:0] two-flop synchroniser, [2] previous synchronised value for edge detect
  logic [2:0]    sync_q;
  rx_state_e     st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  // Receiver state machine: start qualification at mid-bit, then 8 data bits and stop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 3'b111;
      st_q         <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      sh_q         <= 8'd0;
      byte_o       <= 8'd0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], rx_i};
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          if (sync_q[2] && !sync_q[1]) begin
            st_q  <= RX_START;
            cnt_q <= '0;
          end
        end
        RX_START: begin
          // A line back high at mid-bit was a glitch, not a start bit
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            bit_q <= 3'd0;
            st_q  <= rx_s ? RX_IDLE : RX_BITS;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_BITS: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q <= '0;
            sh_q  <= {rx_s, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (rx_s) begin
              byte_o       <= sh_q;
              byte_valid_o <= 1'b1;
            end else begin
              frame_err_o  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader -- receives a length-prefixed image over 8N1 serial and writes it
// word by word to memory starting at BASE_ADDR while holding the core.
//   clk_i, rst_ni              : clock, async active-low reset
//   rx_i                       : serial input
//   mem_re_o / mem_we_o        : read strobe (always 0) / one-cycle write strobe
//   mem_rd_unit_o/mem_wd_unit_o: word-unit encoding
//   mem_addr_o / mem_wd_o      : write byte address / write data
//   access_fault_i, addr_misaligned_i : mmu responses in the write cycle
//   cpu_hold_o, done_o, error_o: core hold and sticky status
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 32000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_rd_unit_o,
  output logic [1:0]  mem_wd_unit_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic        access_fault_i,
  input  logic        addr_misaligned_i,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  logic [7:0]  rx_byte_s;
  logic        rx_valid_s;
  logic        rx_ferr_s;
  logic [7:0]  buf_q;
  logic        buf_vld_q;
  logic        take_s;
  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] len_q;
  logic [31:0] word_q;
  logic [31:0] off_q;
  logic [31:0] len_next_s;
  logic [31:0] word_next_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .byte_o       (rx_byte_s),
    .byte_valid_o (rx_valid_s),
    .frame_err_o  (rx_ferr_s)
  );

  assign mem_re_o      = 1'b0;
  assign mem_rd_unit_o = UNIT_WORD;
  assign mem_wd_unit_o = UNIT_WORD;
  assign len_next_s    = {buf_q, len_q[31:8]};
  assign word_next_s   = {buf_q, word_q[31:8]};

  // Bytes are consumed only in states that collect serial data
  always_comb begin
    take_s = 1'b0;
    case (state_q)
      ST_LEN, ST_DATA: take_s = buf_vld_q;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK:        take_s = buf_vld_q;
`endif
      default:         take_s = 1'b0;
    endcase
  end

  // One-byte holding buffer so a byte finishing during WRITE waits for DATA
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q     <= 8'd0;
      buf_vld_q <= 1'b0;
    end else if (rx_valid_s) begin
      buf_q     <= rx_byte_s;
      buf_vld_q <= 1'b1;
    end else if (take_s) begin
      buf_vld_q <= 1'b0;
    end
  end

  // Loader FSM with registered memory and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_LEN;
      cnt_q      <= 2'd0;
      len_q      <= 32'd0;
      word_q     <= 32'd0;
      off_q      <= 32'd0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= 32'd0;
      mem_wd_o   <= 32'd0;
      cpu_hold_o <= 1'b1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      if (rx_ferr_s && state_q != ST_DONE && state_q != ST_ERROR) begin
        state_q <= ST_ERROR;
        error_o <= 1'b1;
      end else begin
        case (state_q)
          ST_LEN: begin
            if (take_s) begin
              len_q <= len_next_s;
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                if (len_next_s == 32'd0) begin
                  state_q    <= ST_AFTER_DATA;
                  done_o     <= (ST_AFTER_DATA == ST_DONE);
                  cpu_hold_o <= (ST_AFTER_DATA != ST_DONE);
                end else if (len_next_s[1:0] != 2'd0 || len_next_s > 32'(MAX_BYTES)) begin
                  state_q <= ST_ERROR;
                  error_o <= 1'b1;
                end else begin
                  state_q <= ST_DATA;
                end
              end
            end
          end
          ST_DATA: begin
            if (take_s) begin
              word_q <= word_next_s;
              cnt_q  <= cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
              csum_q <= csum_q ^ buf_q;
`endif
              if (cnt_q == 2'd3) begin
                state_q    <= ST_WRITE;
                mem_we_o   <= 1'b1;
                mem_addr_o <= BASE_ADDR + off_q;
                mem_wd_o   <= word_next_s;
              end
            end
          end
          ST_WRITE: begin
            if (access_fault_i || addr_misaligned_i) begin
              state_q <= ST_ERROR;
              error_o <= 1'b1;
            end else begin
              off_q <= off_q + 32'd4;
              if (off_q + 32'd4 == len_q) begin
                state_q    <= ST_AFTER_DATA;
                done_o     <= (ST_AFTER_DATA == ST_DONE);
                cpu_hold_o <= (ST_AFTER_DATA != ST_DONE);
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (take_s) begin
              if (buf_q == csum_q) begin
                state_q    <= ST_DONE;
                done_o     <= 1'b1;
                cpu_hold_o <= 1'b0;
              end else begin
                state_q <= ST_ERROR;
                error_o <= 1'b1;
              end
            end
          end
`endif
          ST_DONE, ST_ERROR: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= ST_ERROR;
            error_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed vector table, hand sequences
// for reset/glitch/checksum corners, and random images against a reference model.
module tb_mem_loader;

  localparam int unsigned CLK_HZ    = 800000;
  localparam int unsigned BAUD      = 100000;
  localparam int unsigned MAX_BYTES = 16;
  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam int          CPB       = CLK_HZ / BAUD;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        access_fault;
  logic        addr_misaligned;
  logic        mem_re, mem_we, cpu_hold, done, error;
  logic [1:0]  mem_rd_unit, mem_wd_unit;
  logic [31:0] mem_addr, mem_wd;

  mem_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_ADDR(BASE), .MAX_BYTES(MAX_BYTES)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rx_i              (rx),
    .mem_re_o          (mem_re),
    .mem_we_o          (mem_we),
    .mem_rd_unit_o     (mem_rd_unit),
    .mem_wd_unit_o     (mem_wd_unit),
    .mem_addr_o        (mem_addr),
    .mem_wd_o          (mem_wd),
    .access_fault_i    (access_fault),
    .addr_misaligned_i (addr_misaligned),
    .cpu_hold_o        (cpu_hold),
    .done_o            (done),
    .error_o           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] img;        // byte i at img[8*i +: 8]
    logic [7:0]   nb;
    logic [7:0]   bad_stop;   // byte index sent with stop=0, 8'hFF none
    logic [7:0]   fault_idx;  // write index that sees a fault
    logic [1:0]   fault_kind; // 0 none, 1 access_fault, 2 addr_misaligned
    logic         exp_done;
    logic         exp_err;
    logic [7:0]   exp_writes;
  } vec_t;

  int          n_cmp;
  int          n_err;
  int          both_high;
  int          re_high;
  int          start_idx;
  int          cur_fault_kind;
  int          cur_fault_idx;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          m_done, m_err;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor plus mmu fault responder
  always @(negedge clk) begin
    if (done && error) both_high <= both_high + 1;
    if (mem_re) re_high <= re_high + 1;
    if (mem_we) begin
      access_fault    <= (cur_fault_kind == 1) && (obs_addr.size() - start_idx == cur_fault_idx);
      addr_misaligned <= (cur_fault_kind == 2) && (obs_addr.size() - start_idx == cur_fault_idx);
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wd);
    end else begin
      access_fault    <= 1'b0;
      addr_misaligned <= 1'b0;
    end
  end

  function automatic vec_t mkv(input logic [255:0] img, input int nb, input int bad,
                               input int fidx, input int fkind, input bit ed, input bit ee,
                               input int ew);
    vec_t v;
    v.img = img; v.nb = 8'(nb); v.bad_stop = 8'(bad); v.fault_idx = 8'(fidx);
    v.fault_kind = 2'(fkind); v.exp_done = ed; v.exp_err = ee; v.exp_writes = 8'(ew);
    return v;
  endfunction

  // Reference model: what the loader should do with a given byte stream
  task automatic model(input vec_t v);
    logic [7:0]  b[32];
    logic [31:0] n;
    for (int i = 0; i < 32; i++) b[i] = v.img[8*i +: 8];
    exp_addr.delete(); exp_data.delete();
    m_done = 1'b0; m_err = 1'b0;
    if (v.bad_stop < 4) begin m_err = 1'b1; return; end
    n = {b[3], b[2], b[1], b[0]};
    if (n == 0) begin m_done = 1'b1; return; end
    if (n % 4 != 0 || n > MAX_BYTES) begin m_err = 1'b1; return; end
    for (int w = 0; w < int'(n / 4); w++) begin
      if (v.bad_stop >= 4 + 4*w && v.bad_stop < 8 + 4*w) begin m_err = 1'b1; return; end
      exp_addr.push_back(BASE + 32'(4*w));
      exp_data.push_back({b[4*w+7], b[4*w+6], b[4*w+5], b[4*w+4]});
      if (v.fault_kind != 0 && v.fault_idx == w) begin m_err = 1'b1; return; end
    end
    m_done = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_image(input vec_t v, input bit add_csum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'd0;
    for (int i = 0; i < int'(v.nb); i++) begin
      b = v.img[8*i +: 8];
      if (i >= 4) x = x ^ b;
      send_byte(b, (i == int'(v.bad_stop)) ? 1'b0 : 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    if (add_csum) send_byte(x, 1'b1);
`else
    if (add_csum) x = 8'd0;
`endif
  endtask

  task automatic apply_reset(input bit chk, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    if (chk) begin
      check({tag, "_rst_flags"}, {59'd0, done, error, cpu_hold, mem_we, mem_re}, 64'b00100);
      check({tag, "_rst_addr_wd"}, {mem_addr, mem_wd}, 64'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (!(done || error) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 64'(done || error), 64'd1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    int nw;
    nw = obs_addr.size() - start_idx;
    check({tag, "_nwrites"}, 64'(nw), 64'(exp_addr.size()));
    for (int i = 0; i < nw && i < exp_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[start_idx + i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(obs_data[start_idx + i]), 64'(exp_data[i]));
    end
  endtask

  task automatic run_case(input vec_t v, input string tag, input bit use_tbl);
    apply_reset(1'b1, tag);
    cur_fault_kind = int'(v.fault_kind);
    cur_fault_idx  = int'(v.fault_idx);
    start_idx      = obs_addr.size();
    model(v);
    send_image(v, 1'b1);
    wait_end(tag);
    check({tag, "_done"}, 64'(done), 64'(m_done));
    check({tag, "_error"}, 64'(error), 64'(m_err));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!m_done));
    if (use_tbl) begin
      check({tag, "_tbl_done_err"}, {62'd0, done, error}, {62'd0, v.exp_done, v.exp_err});
      check({tag, "_tbl_nwrites"}, 64'(obs_addr.size() - start_idx), 64'(v.exp_writes));
    end
    check_writes(tag);
  endtask

  initial begin
    vec_t v;
    int   words;
    int   len;
    n_cmp = 0; n_err = 0;
    cur_fault_kind = 0; cur_fault_idx = 0; start_idx = 0;
    rst_n = 1'b0;
    rx    = 1'b1;

    //           image                                                   nb  bad fidx fk dn er wr
    vecs[0]  = mkv(256'h88776655_44332211_00000008,                      12, 255, 0, 0, 1, 0, 2);
    vecs[1]  = mkv(256'h00000006,                                          4, 255, 0, 0, 0, 1, 0);
    vecs[2]  = mkv(256'hDDCCBBAA_00000004,                                 8, 255, 0, 1, 0, 1, 1);
    vecs[3]  = mkv(256'hDDCCBBAA_00000004,                                 8, 255, 0, 2, 0, 1, 1);
    vecs[4]  = mkv(256'h00000000,                                          4, 255, 0, 0, 1, 0, 0);
    vecs[5]  = mkv(256'hF0E0D0C0_B0A09080_70605040_30201000_00000010,    20, 255, 0, 0, 1, 0, 4);
    vecs[6]  = mkv(256'h00000014,                                          4, 255, 0, 0, 0, 1, 0);
    vecs[7]  = mkv(256'h88776655_44332211_00000008,                      12,   5, 0, 0, 0, 1, 0);
    vecs[8]  = mkv(256'h88776655_44332211_00000008,                      12, 255, 1, 1, 0, 1, 2);
    vecs[9]  = mkv(256'h00010004,                                          4, 255, 0, 0, 0, 1, 0);
    vecs[10] = mkv(256'h00000008,                                          4,   1, 0, 0, 0, 1, 0);
    vecs[11] = mkv(256'h08040201_00000004,                                 8, 255, 0, 0, 1, 0, 1);

    for (int i = 0; i < 12; i++) run_case(vecs[i], $sformatf("tbl%0d", i), 1'b1);

    // Start glitch shorter than half a bit must not start a frame
    apply_reset(1'b1, "glitch");
    cur_fault_kind = 0;
    start_idx = obs_addr.size();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    v = mkv(256'h08040201_00000004, 8, 255, 0, 0, 1, 0, 1);
    model(v);
    send_image(v, 1'b1);
    wait_end("glitch");
    check("glitch_done", 64'(done), 64'd1);
    check_writes("glitch");

    // Reset in the middle of the third data byte, then a clean 4-byte image
    apply_reset(1'b0, "midrst");
    start_idx = obs_addr.size();
    send_byte(8'h08, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {59'd0, done, error, cpu_hold, mem_we, mem_re}, 64'b00100);
    check("midrst_addr_wd", {mem_addr, mem_wd}, 64'd0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    v = mkv(256'hD4C3B2A1_00000004, 8, 255, 0, 0, 1, 0, 1);
    send_image(v, 1'b1);
    wait_end("midrst");
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_nwrites", 64'(obs_addr.size() - start_idx), 64'd1);
    check("midrst_addr", 64'(obs_addr[obs_addr.size() - 1]), 64'h4000_0000);
    check("midrst_data", 64'(obs_data[obs_data.size() - 1]), 64'hD4C3B2A1);

`ifdef LOADER_CHECKSUM_EN
    // Explicit checksum bytes: 0F matches 01^02^04^08, 0E does not
    v = mkv(256'h08040201_00000004, 8, 255, 0, 0, 1, 0, 1);
    apply_reset(1'b1, "csum_ok");
    start_idx = obs_addr.size();
    send_image(v, 1'b0);
    send_byte(8'h0F, 1'b1);
    wait_end("csum_ok");
    check("csum_ok_done_err", {62'd0, done, error}, 64'b10);
    check("csum_ok_nwrites", 64'(obs_addr.size() - start_idx), 64'd1);
    apply_reset(1'b1, "csum_bad");
    start_idx = obs_addr.size();
    send_image(v, 1'b0);
    send_byte(8'h0E, 1'b1);
    wait_end("csum_bad");
    check("csum_bad_done_err", {62'd0, done, error}, 64'b01);
    check("csum_bad_nwrites", 64'(obs_addr.size() - start_idx), 64'd1);
`endif

    // Random images against the reference model
    for (int r = 0; r < 12; r++) begin
      words = int'($urandom_range(0, 4));
      len   = 4 * words;
      if ($urandom_range(0, 5) == 0) len = len + int'($urandom_range(1, 3));
      v = '0;
      v.img[31:0] = 32'(len);
      v.nb = (len % 4 == 0) ? 8'(4 + len) : 8'd4;
      for (int i = 4; i < int'(v.nb); i++) v.img[8*i +: 8] = 8'($urandom_range(0, 255));
      v.bad_stop = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, int'(v.nb) - 1)) : 8'hFF;
      if ($urandom_range(0, 3) == 0) begin
        v.fault_kind = 2'($urandom_range(1, 2));
        v.fault_idx  = 8'($urandom_range(0, (words > 0) ? words - 1 : 0));
      end
      run_case(v, $sformatf("rnd%0d", r), 1'b0);
    end

    check("done_and_error_together", 64'(both_high), 64'd0);
    check("mem_re_seen_high", 64'(re_high), 64'd0);
    check("unit_codes", {60'd0, mem_rd_unit, mem_wd_unit}, 64'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter CLK_HZ, default 32000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter BASE_ADDR, default 32'h4000_0000, first byte address written.
REQ-004 Parameter MAX_BYTES, default 65536, largest accepted image length.
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  asynchronous serial input, 8N1, idle high.
REQ-008 mem_re  output  1  always 0.
REQ-009 mem_we  output  1  one-cycle word write strobe toward mmu.
REQ-010 mem_rd_unit / mem_wd_unit  output  2  word-unit encoding from the shared package.
REQ-011 mem_addr  output  32  write byte address.
REQ-012 mem_wd  output  32  write data.
REQ-013 access_fault / addr_misaligned  input  1  mmu responses, valid in the mem_we cycle.
REQ-014 cpu_hold  output  1  high while loading; the core is held in reset by it.
REQ-015 done / error  output  1  sticky status flags.

Function
REQ-016 The serial receiver SHALL synchronise rx through two flops, detect the falling start edge, re-check it at mid-bit, sample 8 data bits LSB-first at mid-bit, and require stop bit = 1.
REQ-017 Bit period SHALL be CLK_HZ/BAUD cycles, integer-truncated; the counter restarts on every start edge.
REQ-018 Stop bit = 0 SHALL enter ERROR; a start glitch shorter than half a bit SHALL be ignored.
REQ-019 States: LEN, DATA, WRITE, CHECK (macro only), DONE, ERROR.
REQ-020 LEN: collect 4 bytes as little-endian byte count N; then N=0 -> DONE (CHECK with macro), N%4!=0 or N>MAX_BYTES -> ERROR, else DATA.
REQ-021 DATA: assemble 4 bytes little-endian into a word; on the 4th byte -> WRITE.
REQ-022 WRITE: exactly one cycle, mem_we=1, mem_addr=BASE_ADDR+offset, offset increments by 4 after each write.
REQ-023 In the WRITE cycle, access_fault or addr_misaligned SHALL enter ERROR; otherwise -> DATA, or DONE/CHECK after the last word.
REQ-024 A byte completing while in WRITE SHALL NOT be lost: the receiver holds one byte of buffering.
REQ-025 DONE: cpu_hold=0, done=1, further rx traffic ignored.
REQ-026 ERROR: cpu_hold=1, error=1, mem_we=0, further rx traffic ignored; exit only via reset.
REQ-027 done and error SHALL never be high together.

Reset
REQ-028 Asserting reset (low) SHALL immediately force state=LEN, byte/offset counters=0, mem_we=0, mem_addr=0, mem_wd=0, cpu_hold=1, done=0, error=0, receiver idle.
REQ-029 Reset mid-frame or mid-write SHALL discard partial data; no write completes after reset assertion.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, one extra byte SHALL follow the data; CHECK compares it with the XOR of all N data bytes: equal -> DONE, unequal -> ERROR.
REQ-031 Without LOADER_CHECKSUM_EN, there is no CHECK state and no checksum byte; the last write -> DONE.

Structure
REQ-032 The shared package SHALL hold the state enum, word-unit constant, and a clocks-per-bit function.
REQ-033 The serial receiver SHALL be a sub-module uart_rx_core with outputs byte, byte_valid (1-cycle pulse), and frame_err.

Verification
REQ-034 Length 8, data 11 22 33 44 55 66 77 88 -> writes 32'h44332211 @4000_0000, 32'h88776655 @4000_0004; done=1; cpu_hold falls.
REQ-035 Length 6 -> error=1, no mem_we pulse, cpu_hold stays 1.
REQ-036 Length 4, access_fault forced high in the write cycle -> error=1, done=0.
REQ-037 Stop bit driven 0 on the 2nd length byte -> error=1; then reset low -> all outputs return to reset values.
REQ-038 LOADER_CHECKSUM_EN, length 4, data 01 02 04 08, checksum 0F -> done=1; checksum 0E -> error=1 after the write.
REQ-039 Reset asserted during the 3rd data byte of length 8, then a clean 4-byte image -> exactly one write @4000_0000, done=1.
